// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-first read-during-write).
package regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int RF_ZERO_IDX = 0;   // x0, hard-wired zero
  localparam int RF_A0_IDX   = 10;  // a0, exported for result display

endpackage

// File: rtl/regfile_init_ctrl.sv
// Post-reset clear sweep: walks every storage index once, writing zero,
// then parks in RUN until the next reset. The state is exported on state_o
// so the top and any observer can see where the sweep is.
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     sweep_we,
  output logic [ADDRESS_WIDTH-1:0] sweep_addr,
  output logic                     init_done,
  output rf_state_t                state_o
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = {ADDRESS_WIDTH{1'b1}};

  rf_state_t                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  // Next state: advance the sweep counter in INIT, leave after the last index
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RF_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset restarts the sweep from index 0 in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sweep_we   = (state_q == RF_INIT);
  assign sweep_addr = cnt_q;
  assign init_done  = (state_q == RF_RUN);
  assign state_o    = state_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port, single-write-port RV32I integer register file.
// Reads are registered (1-cycle latency), x0 reads as zero, storage is
// cleared by a sweep after reset, and x10 is mirrored on a0.
// Optional feature macro: REGFILE_BYPASS_EN selects write-first behaviour
// for a read and a write to the same non-zero index in one cycle; when
// undefined the read returns the old contents (read-first).
//
// Handshake: rd_valid[i] is high for exactly the cycle after a RUN-state
// edge that sampled rd_en[i]=1; rd_data slice i is meaningful only then and
// otherwise holds its last value. There is no back-pressure.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD-1:0]               rd_en,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_valid,
  input  logic                            wr_en,
  input  logic [ADDRESS_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic [DATA_WIDTH-1:0]           a0,
  output logic                            init_done
);

  localparam int                       DEPTH     = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(RF_ZERO_IDX);
  localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR   = ADDRESS_WIDTH'(RF_A0_IDX);

  logic                     sweep_we;
  logic [ADDRESS_WIDTH-1:0] sweep_addr;
  rf_state_t                ctrl_state;
  logic                     run;

  logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]        mem_d [DEPTH];
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]            rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]        a0_q, a0_d;
  logic                         wr_fire;

  regfile_init_ctrl #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_init_ctrl (
    .clk        (clk),
    .rst        (rst),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .init_done  (init_done),
    .state_o    (ctrl_state)
  );

  assign run     = (ctrl_state == RF_RUN);
  assign wr_fire = run && wr_en && (wr_addr != ZERO_ADDR);

  // Storage update: sweep clears during INIT, writeback port writes in RUN
  always_comb begin
    mem_d = mem_q;
    if (sweep_we) begin
      mem_d[sweep_addr] = '0;
    end else if (wr_fire) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read ports: independent, registered, x0 forced to zero
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDRESS_WIDTH-1:0] ra;
      ra = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (!run) begin
        rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (rd_en[i]) begin
        rd_valid_d[i] = 1'b1;
        if (ra == ZERO_ADDR) begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_fire && (wr_addr == ra)) begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
`endif
        end else begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
        end
      end
    end
  end

  // a0 mirror: follows the same edge that writes x10, zero during INIT
  always_comb begin
    a0_d = a0_q;
    if (!run) begin
      a0_d = '0;
    end else if (wr_fire && (wr_addr == A0_ADDR)) begin
      a0_d = wr_data;
    end
  end

  // Storage array register; the sweep provides the clear, so no reset here
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      a0_q       <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      a0_q       <= a0_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign a0       = a0_q;

endmodule
